bounce_mover_2d: RTL and testbench

Parametrised two-axis successor to the single-axis object mover. Advances an on-screen object once per frame in 1/2^FP_SHIFT-pixel fixed point on both X and Y, clamps to a configurable frame window, and reflects speed on any wall hit. Adds a pause input, an external collision reflection, optional speed-up, and per-axis bounce pulses. Sits between the frame-timing block and the object's draw/square module.

---
 rtl/bounce_mover_2d.sv | 187 ++++++++++++++++++
 tb/tb_bounce_mover_2d.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_mover_2d.sv
// bounce_mover_2d: two-axis fixed-point object mover for a frame-based display.
// Once per frame the object advances by its speed on X and Y. It is held inside
// the frame window, and its speed is reflected at the walls and on external
// collisions. bounceX/bounceY pulse for one cycle when a wall reflection happens.
// Optional feature macro: BOUNCE_MOVER_SPEED_UP_EN. When it is defined, speedUp
// pulses raise the speed magnitude up to MAX_SPEED. When it is undefined, the
// speedUp port exists but has no effect.
module bounce_mover_2d #(
  parameter int INITIAL_X       = 256,
  parameter int INITIAL_Y       = 256,
  parameter int INITIAL_X_SPEED = 40,
  parameter int INITIAL_Y_SPEED = 0,
  parameter int OBJECT_WIDTH_X  = 64,
  parameter int OBJECT_HIGHT_Y  = 64,
  parameter int FRAME_LEFT      = 32,
  parameter int FRAME_TOP       = 32,
  parameter int FRAME_RIGHT     = 512,
  parameter int FRAME_BOTTOM    = 480,
  parameter int FP_SHIFT        = 6,
  parameter int SPEED_STEP      = 8,
  parameter int MAX_SPEED       = 256
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               collision,
  input  logic               speedUp,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               bounceX,
  output logic               bounceY
);

  // Window limits and initial values in fixed point. The max top-left leaves
  // room for the whole object inside the screen extent.
  localparam logic signed [31:0] X_MIN  = FRAME_LEFT << FP_SHIFT;
  localparam logic signed [31:0] Y_MIN  = FRAME_TOP << FP_SHIFT;
  localparam logic signed [31:0] X_MAX  = (FRAME_RIGHT - OBJECT_WIDTH_X) << FP_SHIFT;
  localparam logic signed [31:0] Y_MAX  = (FRAME_BOTTOM - OBJECT_HIGHT_Y) << FP_SHIFT;
  localparam logic signed [31:0] X_INIT = INITIAL_X << FP_SHIFT;
  localparam logic signed [31:0] Y_INIT = INITIAL_Y << FP_SHIFT;
  localparam logic signed [31:0] VX_INIT = INITIAL_X_SPEED;
  localparam logic signed [31:0] VY_INIT = INITIAL_Y_SPEED;
  localparam logic signed [31:0] STEP    = SPEED_STEP;
  localparam logic signed [31:0] SMAX    = MAX_SPEED;

  typedef enum logic [2:0] {
    IDLE_ST,
    MOVE_ST,
    REFLECT_ST,
    POSITION_CHANGE_ST,
    POSITION_LIMITS_ST
  } state_t;

  typedef struct packed {
    logic signed [31:0] pos;
    logic signed [31:0] spd;
    logic               hit;
  } axis_t;

  state_t             state;
  logic signed [31:0] xpos;
  logic signed [31:0] ypos;
  logic signed [31:0] xspd;
  logic signed [31:0] yspd;
  logic               col_flag;
  logic               su;
  axis_t              lim_x;
  axis_t              lim_y;

  // Grows the magnitude of a non-zero speed by STEP, keeps its sign, and
  // saturates at SMAX. A zero speed stays zero.
  function automatic logic signed [31:0] speed_up(input logic signed [31:0] s,
                                                  input logic en);
    logic signed [31:0] r;
    r = s;
    if (en) begin
      if (s > 0)
        r = (s >= SMAX - STEP) ? SMAX : s + STEP;
      else if (s < 0)
        r = (s <= STEP - SMAX) ? -SMAX : s - STEP;
    end
    return r;
  endfunction

  // Clamps one axis to [lo, hi]. The speed is turned back toward the window
  // only if it still points outward. A position exactly at a limit is legal.
  function automatic axis_t limit_axis(input logic signed [31:0] pos,
                                       input logic signed [31:0] spd,
                                       input logic signed [31:0] lo,
                                       input logic signed [31:0] hi);
    axis_t r;
    r.pos = pos;
    r.spd = spd;
    r.hit = 1'b0;
    if (pos < lo) begin
      r.pos = lo;
      r.hit = 1'b1;
      if (spd < 0) r.spd = -spd;
    end else if (pos > hi) begin
      r.pos = hi;
      r.hit = 1'b1;
      if (spd > 0) r.spd = -spd;
    end
    return r;
  endfunction

`ifdef BOUNCE_MOVER_SPEED_UP_EN
  assign su = speedUp;
`else
  assign su = speedUp & 1'b0;
`endif

  // Wall evaluation of the freshly updated position, consumed in POSITION_LIMITS_ST.
  always_comb begin
    lim_x = limit_axis(xpos, xspd, X_MIN, X_MAX);
    lim_y = limit_axis(ypos, yspd, Y_MIN, Y_MAX);
  end

  // Frame sequencer: reflect, then advance, then clamp. Outputs are registered.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE_ST;
      xpos     <= X_INIT;
      ypos     <= Y_INIT;
      xspd     <= VX_INIT;
      yspd     <= VY_INIT;
      col_flag <= 1'b0;
      bounceX  <= 1'b0;
      bounceY  <= 1'b0;
    end else begin
      bounceX <= 1'b0;
      bounceY <= 1'b0;
      case (state)
        IDLE_ST: begin
          xpos     <= X_INIT;
          ypos     <= Y_INIT;
          xspd     <= VX_INIT;
          yspd     <= VY_INIT;
          col_flag <= 1'b0;
          if (startOfFrame) state <= MOVE_ST;
        end
        MOVE_ST: begin
          xspd <= speed_up(xspd, su);
          yspd <= speed_up(yspd, su);
          if (startOfFrame && !enable)
            col_flag <= 1'b0;
          else if (collision)
            col_flag <= 1'b1;
          if (startOfFrame && enable) state <= REFLECT_ST;
        end
        REFLECT_ST: begin
          // A collision seen in this cycle belongs to the next frame.
          xspd     <= speed_up(col_flag ? -xspd : xspd, su);
          yspd     <= speed_up(col_flag ? -yspd : yspd, su);
          col_flag <= collision;
          state    <= POSITION_CHANGE_ST;
        end
        POSITION_CHANGE_ST: begin
          xpos <= xpos + xspd;
          ypos <= ypos + yspd;
          xspd <= speed_up(xspd, su);
          yspd <= speed_up(yspd, su);
          if (collision) col_flag <= 1'b1;
          state <= POSITION_LIMITS_ST;
        end
        POSITION_LIMITS_ST: begin
          xpos    <= lim_x.pos;
          ypos    <= lim_y.pos;
          xspd    <= speed_up(lim_x.spd, su);
          yspd    <= speed_up(lim_y.spd, su);
          bounceX <= lim_x.hit;
          bounceY <= lim_y.hit;
          if (collision) col_flag <= 1'b1;
          state <= MOVE_ST;
        end
        default: state <= IDLE_ST;
      endcase
    end
  end

  // Pixel position: floor of the fixed-point value, kept to the output width.
  assign topLeftX = 11'(xpos >>> FP_SHIFT);
  assign topLeftY = 11'(ypos >>> FP_SHIFT);

endmodule

// File: tb/tb_bounce_mover_2d.sv
// Bench for bounce_mover_2d: directed frame table, hand sequences, and randomized
// frames checked against a frame-level arithmetic model.
module tb_bounce_mover_2d;
  localparam int FP   = 6;
  localparam int STEP = 8;
  localparam int SMAX = 256;
  localparam longint XMIN = 32 * 64;
  localparam longint XMAX = 448 * 64;
  localparam longint YMIN = 32 * 64;
  localparam longint YMAX = 416 * 64;
`ifdef BOUNCE_MOVER_SPEED_UP_EN
  localparam bit SU_EN = 1'b1;
`else
  localparam bit SU_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetN = 1'b1;
  logic sof = 1'b0, en = 1'b1, col = 1'b0, su = 1'b0;
  logic signed [10:0] ax, ay, bx, by;
  logic abx, aby, bbx, bby;
  int errors = 0;
  int checks = 0;
  int cnt_abx, cnt_aby, cnt_bbx, cnt_bby;

  typedef struct {
    bit en;
    bit col;
    int ax, ay, bx, by;
    int bbx, bby;
  } tvec_t;

  always #5 clk = ~clk;

  bounce_mover_2d dut_a (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en),
    .collision(col), .speedUp(su),
    .topLeftX(ax), .topLeftY(ay), .bounceX(abx), .bounceY(aby));

  bounce_mover_2d #(
    .INITIAL_X(447), .INITIAL_Y(34), .INITIAL_X_SPEED(128), .INITIAL_Y_SPEED(-64)
  ) dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en),
    .collision(col), .speedUp(su),
    .topLeftX(bx), .topLeftY(by), .bounceX(bbx), .bounceY(bby));

  // ---------------- reference model (frame level) ----------------
  longint m_x[2], m_y[2], m_vx[2], m_vy[2];
  bit     m_flag[2], m_idle[2];
  int     m_bx[2], m_by[2];

  function automatic void m_reset();
    m_x[0] = 256 * 64; m_y[0] = 256 * 64; m_vx[0] = 40;  m_vy[0] = 0;
    m_x[1] = 447 * 64; m_y[1] = 34 * 64;  m_vx[1] = 128; m_vy[1] = -64;
    for (int i = 0; i < 2; i++) begin
      m_flag[i] = 1'b0; m_idle[i] = 1'b1; m_bx[i] = 0; m_by[i] = 0;
    end
  endfunction

  function automatic longint m_fast(longint v);
    longint mag;
    if (!SU_EN || v == 0) return v;
    mag = (v < 0) ? -v : v;
    mag = mag + STEP;
    if (mag > SMAX) mag = SMAX;
    return (v < 0) ? -mag : mag;
  endfunction

  function automatic void m_axis(inout longint p, inout longint v, input longint lo,
                                 input longint hi, output int hit);
    p = p + v;
    hit = 0;
    if (p < lo) begin p = lo; hit = 1; if (v < 0) v = -v; end
    else if (p > hi) begin p = hi; hit = 1; if (v > 0) v = -v; end
  endfunction

  function automatic void m_frame(int i, bit e);
    m_bx[i] = 0; m_by[i] = 0;
    if (m_idle[i]) begin m_idle[i] = 1'b0; return; end
    if (!e) begin m_flag[i] = 1'b0; return; end
    if (m_flag[i]) begin m_vx[i] = -m_vx[i]; m_vy[i] = -m_vy[i]; m_flag[i] = 1'b0; end
    m_axis(m_x[i], m_vx[i], XMIN, XMAX, m_bx[i]);
    m_axis(m_y[i], m_vy[i], YMIN, YMAX, m_by[i]);
  endfunction

  function automatic int m_tl(longint p);
    logic signed [10:0] t;
    t = 11'(p >>> FP);
    return int'(t);
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_cnt();
    cnt_abx = 0; cnt_aby = 0; cnt_bbx = 0; cnt_bby = 0;
  endtask

  task automatic step(input bit s, input bit c, input bit u);
    sof = s; col = c; su = u;
    @(posedge clk);
    @(negedge clk);
    cnt_abx += int'(abx); cnt_aby += int'(aby);
    cnt_bbx += int'(bbx); cnt_bby += int'(bby);
  endtask

  task automatic do_reset();
    sof = 0; col = 0; su = 0; en = 1;
    @(negedge clk) resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    m_reset();
  endtask

  // Two gap cycles (collision optional in the first), the frame pulse, four
  // processing cycles, then compare against fixed expectations.
  task automatic frame_exp(input tvec_t r, input string name);
    clr_cnt();
    en = r.en;
    step(0, r.col, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    check({name, ".ax"}, ax, r.ax);
    check({name, ".ay"}, ay, r.ay);
    check({name, ".bx"}, bx, r.bx);
    check({name, ".by"}, by, r.by);
    check({name, ".a_bounceX"}, cnt_abx, 0);
    check({name, ".a_bounceY"}, cnt_aby, 0);
    check({name, ".b_bounceX"}, cnt_bbx, r.bbx);
    check({name, ".b_bounceY"}, cnt_bby, r.bby);
  endtask

  task automatic frame_rand(input int n);
    int gap;
    bit e, c, u;
    string name;
    name = $sformatf("rnd%0d", n);
    gap = $urandom_range(1, 4);
    e = ($urandom_range(0, 3) != 0);
    clr_cnt();
    en = e;
    for (int g = 0; g < gap; g++) begin
      c = ($urandom_range(0, 3) == 0);
      u = ($urandom_range(0, 7) == 0);
      if (!m_idle[0]) begin
        for (int i = 0; i < 2; i++) begin
          if (c) m_flag[i] = 1'b1;
          if (u) begin m_vx[i] = m_fast(m_vx[i]); m_vy[i] = m_fast(m_vy[i]); end
        end
      end
      step(0, c, u);
    end
    step(1, 0, 0);
    m_frame(0, e);
    m_frame(1, e);
    for (int p = 0; p < 4; p++) begin
      c = ($urandom_range(0, 3) == 0);
      step(0, c, 0);
      if (c) begin m_flag[0] = 1'b1; m_flag[1] = 1'b1; end
    end
    check({name, ".ax"}, ax, m_tl(m_x[0]));
    check({name, ".ay"}, ay, m_tl(m_y[0]));
    check({name, ".bx"}, bx, m_tl(m_x[1]));
    check({name, ".by"}, by, m_tl(m_y[1]));
    check({name, ".a_bounceX"}, cnt_abx, m_bx[0]);
    check({name, ".a_bounceY"}, cnt_aby, m_by[0]);
    check({name, ".b_bounceX"}, cnt_bbx, m_bx[1]);
    check({name, ".b_bounceY"}, cnt_bby, m_by[1]);
  endtask

  // ---------------- test sequence ----------------
  tvec_t tab[7];
  tvec_t r;

  initial begin
    // en, col, ax, ay, bx, by, b bounceX, b bounceY
    tab[0] = '{1, 0, 256, 256, 447, 34, 0, 0};  // leaves idle, no motion
    tab[1] = '{1, 0, 256, 256, 448, 33, 1, 0};  // B clamps at right wall
    tab[2] = '{1, 0, 257, 256, 446, 32, 0, 0};  // B exactly at top limit
    tab[3] = '{1, 1, 256, 256, 448, 33, 0, 0};  // collision reflects both
    tab[4] = '{0, 1, 256, 256, 448, 33, 0, 0};  // disabled: hold, flag dropped
    tab[5] = '{1, 0, 256, 256, 448, 34, 1, 0};  // B hits right wall again
    tab[6] = '{1, 0, 255, 256, 446, 35, 0, 0};

    #2 resetN = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.ax", ax, 256);
    check("reset.ay", ay, 256);
    check("reset.bx", bx, 447);
    check("reset.by", by, 34);
    check("reset.bounce", {30'd0, abx, aby} | {30'd0, bbx, bby}, 0);
    resetN = 1'b1;
    m_reset();

    for (int i = 0; i < 7; i++) frame_exp(tab[i], $sformatf("tab%0d", i));

    // Reset while the position update is pending.
    en = 1;
    step(1, 0, 0);
    step(0, 0, 0);
    resetN = 1'b0;
    #1;
    check("midrst.ax", ax, 256);
    check("midrst.ay", ay, 256);
    check("midrst.bx", bx, 447);
    check("midrst.by", by, 34);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    frame_exp('{1, 0, 256, 256, 447, 34, 0, 0}, "midrst_idle");
    frame_exp('{1, 0, 256, 256, 448, 33, 1, 0}, "midrst_move");

    // Thirty speed-up pulses, then two frames.
    do_reset();
    frame_exp('{1, 0, 256, 256, 447, 34, 0, 0}, "su_idle");
    for (int k = 0; k < 30; k++) begin
      step(0, 0, 1);
      step(0, 0, 0);
    end
    r = '{1, 0, SU_EN ? 260 : 256, 256, 448, SU_EN ? 32 : 33, 1, SU_EN ? 1 : 0};
    frame_exp(r, "su_f1");
    r = '{1, 0, SU_EN ? 264 : 257, 256, SU_EN ? 444 : 446, SU_EN ? 36 : 32, 0, 0};
    frame_exp(r, "su_f2");

    // Randomized frames against the model.
    do_reset();
    for (int n = 0; n < 200; n++) frame_rand(n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
